fetch_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter and sequences instruction fetch. It arbitrates between sequential advance, hazard stalls, MEM-stage branch/jump redirects and trap entry. It handshakes with instruction memory and keeps the request address stable while a fetch is outstanding. It drives the pipeline-register flush lines on every accepted redirect; it sits between the hazard unit, the MEM stage and the IF/ID register.

---
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: hazard/MEM/trap inputs, instruction-memory handshake and IF-stage outputs.
// master = the sequencer, slave = the surrounding pipeline and instruction memory.
interface fetch_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_req;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [2:0]  flush;
  logic        misalign_fault;

  modport master (
    input  stall, branch_taken, branch_target, trap_req, imem_ready,
    output imem_req, pc, fetch_valid, flush, misalign_fault
  );

  modport slave (
    output stall, branch_taken, branch_target, trap_req, imem_ready,
    input  imem_req, pc, fetch_valid, flush, misalign_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: sequential advance, stalls, branch/trap redirects, imem handshake.
// Optional FETCH_SEQUENCER_PERF_EN adds saturating redirect_cnt/stall_cnt outputs.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [15:0]       redirect_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_trap_q, pend_trap_d;

  logic        redir_req;
  logic        redir_mis;
  logic        redir_trap;
  logic [31:0] redir_tgt;

  logic        imem_req;
  logic        fetch_valid;
  logic [2:0]  flush;
  logic        misalign_fault;

  // A misaligned branch is turned into a trap; trap_req masks the branch entirely.
  assign redir_req  = bus.trap_req | bus.branch_taken;
  assign redir_mis  = bus.branch_taken & ~bus.trap_req & (bus.branch_target[1:0] != 2'b00);
  assign redir_trap = bus.trap_req | redir_mis;
  assign redir_tgt  = redir_trap ? TRAP_VECTOR : bus.branch_target;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_tgt_d     = pend_tgt_q;
    pend_vld_d     = pend_vld_q;
    pend_trap_d    = pend_trap_q;
    imem_req       = 1'b0;
    fetch_valid    = 1'b0;
    flush          = 3'b000;
    misalign_fault = 1'b0;

    case (state_q)
      ST_BOOT: begin
        flush   = 3'b111;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (redir_req) begin
          flush          = 3'b111;
          misalign_fault = redir_mis;
          pc_d           = redir_tgt;
        end else if (!bus.imem_ready) begin
          state_d = ST_WAIT;
        end else if (!bus.stall) begin
          fetch_valid = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end

      ST_WAIT: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          state_d    = ST_FETCH;
          pend_vld_d = 1'b0;
          if (redir_req) begin
            flush          = 3'b111;
            misalign_fault = redir_mis;
            pc_d           = redir_tgt;
          end else if (pend_vld_q) begin
            pc_d = pend_tgt_q;
          end else if (!bus.stall) begin
            fetch_valid = 1'b1;
            pc_d        = pc_q + 32'd4;
          end
        end else if (redir_req) begin
          // pc must hold while the request is outstanding, so park the redirect.
          flush          = 3'b111;
          misalign_fault = redir_mis;
          if (!(pend_vld_q && pend_trap_q && !redir_trap)) begin
            pend_vld_d  = 1'b1;
            pend_tgt_d  = redir_tgt;
            pend_trap_d = redir_trap;
          end
        end
      end

      default: state_d = ST_BOOT;
    endcase

    if (rst) begin
      imem_req       = 1'b0;
      fetch_valid    = 1'b0;
      flush          = 3'b111;
      misalign_fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      pend_tgt_q  <= 32'd0;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
    end
  end

  assign bus.imem_req       = imem_req;
  assign bus.pc             = pc_q;
  assign bus.fetch_valid    = fetch_valid;
  assign bus.flush          = flush;
  assign bus.misalign_fault = misalign_fault;

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        redir_acc;
  logic        stall_evt;

  assign redir_acc = (state_q != ST_BOOT) & redir_req;
  assign stall_evt = (state_q != ST_BOOT) & ~fetch_valid & ~redir_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      if (redir_acc && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
      if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] redirect_cnt;
  logic [15:0] stall_cnt;
`endif

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_SEQUENCER_PERF_EN
    ,
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        fv;
    logic [2:0]  flush;
    logic        mis;
    logic [15:0] rc;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: address being fetched, whether a response is still owed, a parked redirect.
  logic [31:0] m_pc;
  logic [31:0] m_pend_tgt;
  bit          m_boot, m_out, m_pend, m_pend_trap;
  logic [15:0] m_rc, m_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t,
                      input bit tr, input bit rdy);
    exp_t        e;
    bit          redir, is_trap;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    bus.trap_req      = tr;
    bus.imem_ready    = rdy;

    redir   = b || tr;
    is_trap = tr || (b && (t[1:0] != 2'b00));
    tgt     = is_trap ? 32'h0000_0080 : t;

    e.pc = m_pc; e.req = 1'b0; e.fv = 1'b0; e.flush = 3'b000; e.mis = 1'b0;
    e.rc = m_rc; e.sc = m_sc;

    if (r) begin
      e.flush = 3'b111;
      m_boot = 1; m_pc = 32'h0; m_out = 0; m_pend = 0; m_rc = 0; m_sc = 0;
    end else if (m_boot) begin
      e.flush = 3'b111;
      m_boot  = 0;
    end else begin
      e.req = 1'b1;
      if (redir) begin
        e.flush = 3'b111;
        e.mis   = b && !tr && (t[1:0] != 2'b00);
        m_rc    = sat_inc(m_rc);
        if (!m_out || rdy) begin
          m_pc = tgt; m_pend = 0; m_out = 0;
        end else if (!(m_pend && m_pend_trap && !is_trap)) begin
          m_pend = 1; m_pend_tgt = tgt; m_pend_trap = is_trap;
        end
      end else begin
        if (!rdy) begin
          m_out = 1;
        end else begin
          m_out = 0;
          if (m_pend) begin
            m_pc   = m_pend_tgt;
            m_pend = 0;
          end else if (!s) begin
            e.fv = 1'b1;
            m_pc = m_pc + 32'd4;
          end
        end
        if (!e.fv) m_sc = sat_inc(m_sc);
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: one expected record per presented cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",             bus.pc,                     e.pc);
      chk("imem_req",       32'(bus.imem_req),          32'(e.req));
      chk("fetch_valid",    32'(bus.fetch_valid),       32'(e.fv));
      chk("flush",          32'(bus.flush),             32'(e.flush));
      chk("misalign_fault", 32'(bus.misalign_fault),    32'(e.mis));
`ifdef FETCH_SEQUENCER_PERF_EN
      chk("redirect_cnt",   32'(redirect_cnt),          32'(e.rc));
      chk("stall_cnt",      32'(stall_cnt),             32'(e.sc));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.trap_req = 0; bus.imem_ready = 0;
    @(posedge clk);
    m_boot = 1; m_pc = 32'h0; m_out = 0; m_pend = 0; m_pend_trap = 0;
    m_pend_tgt = 32'h0; m_rc = 0; m_sc = 0;

    // Reset, boot, then back-to-back fetch 0,4,8,12...
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
    // Branch in FETCH to 0x40.
    step(0, 0, 1, 32'h40, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // WAIT: branch to 0x100, trap next cycle, response after 3 cycles.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Stall at 0x20 for two cycles, then release.
    step(0, 0, 1, 32'h20, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Misaligned target, then pending trap not overwritten by a later branch.
    step(0, 0, 1, 32'h42, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Wrap from 0xFFFF_FFFC to 0.
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Reset while waiting with a parked redirect.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      t = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0,
           t,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
